// File: rtl/write8to32.sv
// write8to32: packs a stream of bytes into 32-bit words, writes each word to
// memory at consecutive addresses from a latched base, and echoes every
// written word on the _valid/_out0 stream.
// Build option: define WRITE8TO32_BIG_ENDIAN_EN to place byte 0 in bits[31:24]
// instead of bits[7:0]. Timing is identical in both byte orders.
module write8to32 #(
    parameter int ADDR_STRIDE = 4
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic               _ready,
    input  logic signed [31:0] base,
    input  logic signed [31:0] count,
    input  logic        [7:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [31:0] mem_addr,
    output logic        [31:0] mem_wdata,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               _done,
    output logic               _valid,
    output logic signed [31:0] _out0
);

    localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Place one byte into its lane of the word being assembled.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] res;
        logic [1:0]  pos;
        res = word;
`ifdef WRITE8TO32_BIG_ENDIAN_EN
        pos = 2'd3 - lane;
`else
        pos = lane;
`endif
        case (pos)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    state_t      state_r, state_n;
    logic [31:0] addr_cur_r, addr_cur_n;   // address of the next word to write
    logic [31:0] count_r, count_n;
    logic [31:0] word_idx_r, word_idx_n;
    logic [1:0]  byte_idx_r, byte_idx_n;
    logic [31:0] pack_r, pack_n;
    logic        in_ready_r, in_ready_n;
    logic        mem_we_r, mem_we_n;
    logic [31:0] mem_addr_r, mem_addr_n;
    logic [31:0] mem_wdata_r, mem_wdata_n;
    logic        done_r, done_n;
    logic        valid_r, valid_n;
    logic [31:0] out0_r, out0_n;

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign _done     = done_r;
    assign _valid    = valid_r;
    assign _out0     = out0_r;

    // Next-state and next-register computation; every output is registered.
    always_comb begin
        state_n     = state_r;
        addr_cur_n  = addr_cur_r;
        count_n     = count_r;
        word_idx_n  = word_idx_r;
        byte_idx_n  = byte_idx_r;
        pack_n      = pack_r;
        in_ready_n  = in_ready_r;
        mem_we_n    = mem_we_r;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        done_n      = done_r;
        valid_n     = valid_r;
        out0_n      = out0_r;
        case (state_r)
            ST_IDLE: begin
                done_n     = 1'b1;
                in_ready_n = 1'b0;
                if (_start) begin
                    addr_cur_n = base;
                    count_n    = count;
                    word_idx_n = 32'd0;
                    byte_idx_n = 2'd0;
                    if (count <= 32'sd0) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n    = ST_COLLECT;
                        in_ready_n = 1'b1;
                        done_n     = 1'b0;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (in_valid && in_ready_r) begin
                    pack_n     = insert_byte(pack_r, byte_idx_r, in_data);
                    byte_idx_n = byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        state_n     = ST_WRITE;
                        in_ready_n  = 1'b0;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = addr_cur_r;
                        mem_wdata_n = pack_n;
                    end else begin
                        state_n = ST_COLLECT;
                    end
                end else begin
                    state_n = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_n    = ST_ECHO;
                    mem_we_n   = 1'b0;
                    out0_n     = mem_wdata_r;
                    valid_n    = 1'b1;
                    word_idx_n = word_idx_r + 32'd1;
                    addr_cur_n = addr_cur_r + STRIDE;
                end else begin
                    state_n = ST_WRITE;
                end
            end
            ST_ECHO: begin
                if (_ready) begin
                    valid_n = 1'b0;
                    if (word_idx_r == count_r) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = ST_COLLECT;
                        in_ready_n = 1'b1;
                        byte_idx_n = 2'd0;
                    end
                end else begin
                    state_n = ST_ECHO;
                end
            end
            ST_DONE: begin
                state_n    = ST_IDLE;
                done_n     = 1'b1;
                valid_n    = 1'b0;
                in_ready_n = 1'b0;
            end
            default: begin
                state_n    = ST_IDLE;
                done_n     = 1'b1;
                valid_n    = 1'b0;
                in_ready_n = 1'b0;
                mem_we_n   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that drops any partial work.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_r     <= ST_IDLE;
            addr_cur_r  <= 32'd0;
            count_r     <= 32'd0;
            word_idx_r  <= 32'd0;
            byte_idx_r  <= 2'd0;
            pack_r      <= 32'd0;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            done_r      <= 1'b1;
            valid_r     <= 1'b0;
            out0_r      <= 32'd0;
        end else begin
            state_r     <= state_n;
            addr_cur_r  <= addr_cur_n;
            count_r     <= count_n;
            word_idx_r  <= word_idx_n;
            byte_idx_r  <= byte_idx_n;
            pack_r      <= pack_n;
            in_ready_r  <= in_ready_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
            done_r      <= done_n;
            valid_r     <= valid_n;
            out0_r      <= out0_n;
        end
    end

endmodule

// File: tb/tb_write8to32.sv
// Self-checking bench for write8to32: directed scenarios plus random
// transactions, checked against a word-list model built from the byte stream.
module tb_write8to32;

    logic               clk;
    logic               rst;
    logic               start;
    logic               rdy;
    logic signed [31:0] base;
    logic signed [31:0] count;
    logic        [7:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] mem_addr;
    logic        [31:0] mem_wdata;
    logic               mem_we;
    logic               mem_ack;
    logic               done;
    logic               valid;
    logic signed [31:0] out0;

    write8to32 #(.ADDR_STRIDE(4)) dut (
        ._clock(clk), ._reset(rst), ._start(start), ._ready(rdy),
        .base(base), .count(count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_ack(mem_ack), ._done(done), ._valid(valid),
        ._out0(out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0]  bq[$];
    logic [7:0]  src[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] ec_q[$];
    int consumed, stall, valid_cyc;
    bit we_seen, ir_seen, done_s, acc;
    int ackd, rdyd, we_age, v_age;
    bit rrand, vrand;
    logic we_prev, ack_prev, val_prev, rdy_prev, rst_prev;
    logic [31:0] addr_prev, data_prev, out0_prev;

    // Reference packing of four stream bytes into one memory word.
    function automatic logic [31:0] pack4(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
`ifdef WRITE8TO32_BIG_ENDIAN_EN
        return {a0, a1, a2, a3};
`else
        return {a3, a2, a1, a0};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample/check at negedge, then drive inputs 1ns after posedge.
    task automatic tick();
        @(negedge clk);
        if (!rst_prev) begin
            if (we_prev && !ack_prev) begin
                chk("we_hold", 32'(mem_we), 32'd1);
                chk("addr_hold", mem_addr, addr_prev);
                chk("data_hold", mem_wdata, data_prev);
            end
            if (val_prev && !rdy_prev) begin
                chk("valid_hold", 32'(valid), 32'd1);
                chk("out0_hold", out0, out0_prev);
            end
        end
        chk("inready_excl", 32'(in_ready && (mem_we || valid)), 32'd0);
        acc = in_valid && in_ready;
        if (acc) consumed++;
        if (mem_we && mem_ack) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (mem_we && !mem_ack) stall++;
        if (valid && rdy) ec_q.push_back(out0);
        if (valid) valid_cyc++;
        if (mem_we) we_seen = 1'b1;
        if (in_ready) ir_seen = 1'b1;
        done_s    = done;
        we_prev   = mem_we;   ack_prev  = mem_ack;
        val_prev  = valid;    rdy_prev  = rdy;
        rst_prev  = rst;      addr_prev = mem_addr;
        data_prev = mem_wdata; out0_prev = out0;
        @(posedge clk);
        #1;
        if (acc && bq.size() > 0) void'(bq.pop_front());
        in_valid = (bq.size() > 0) && (vrand ? ($urandom_range(0, 1) == 1) : 1'b1);
        in_data  = (bq.size() > 0) ? bq[0] : 8'($urandom);
        if (mem_we) begin
            mem_ack = (we_age >= ackd);
            we_age++;
        end else begin
            we_age  = 0;
            mem_ack = (ackd == 0);
        end
        if (valid) begin
            rdy = rrand ? ($urandom_range(0, 1) == 1) : (v_age >= rdyd);
            v_age++;
        end else begin
            v_age = 0;
            rdy = rrand ? ($urandom_range(0, 1) == 1) : (rdyd == 0);
        end
    endtask

    task automatic clear_rec();
        wa_q.delete(); wd_q.delete(); ec_q.delete();
        consumed = 0; stall = 0; valid_cyc = 0;
        we_seen = 1'b0; ir_seen = 1'b0;
    endtask

    // Run one start..done transaction on the bytes in src and check it.
    task automatic run_txn(input string tag, input logic [31:0] b, input logic [31:0] c,
                           input int ad, input int rd, input bit rr, input bit vr,
                           input int extra);
        int nw;
        int n;
        bit done_seen;
        logic [31:0] ew;
        nw = ($signed(c) > 0) ? int'(c) : 0;
        ackd = ad; rdyd = rd; rrand = rr; vrand = vr;
        bq = src;
        repeat (extra) bq.push_back(8'($urandom));
        clear_rec();
        base = b; count = c; start = 1'b1;
        tick();
        start = 1'b0; base = $urandom; count = $urandom;
        n = 0; done_seen = 1'b0;
        while (!done_seen && n < 2000) begin
            tick();
            n++;
            done_seen = done_s;
        end
        chk({tag, "_done"}, 32'(done_seen), 32'd1);
        if (nw == 0) chk({tag, "_done_lat"}, 32'(n <= 2), 32'd1);
        repeat (3) tick();
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(nw));
        chk({tag, "_nechoes"}, 32'(ec_q.size()), 32'(nw));
        chk({tag, "_consumed"}, 32'(consumed), 32'(4 * nw));
        chk({tag, "_stall"}, 32'(stall), 32'(nw * ad));
        if (!rr) chk({tag, "_valid_cyc"}, 32'(valid_cyc), 32'(nw * (rd + 1)));
        if (nw == 0) begin
            chk({tag, "_we_seen"}, 32'(we_seen), 32'd0);
            chk({tag, "_ir_seen"}, 32'(ir_seen), 32'd0);
        end
        for (int i = 0; i < nw; i++) begin
            ew = pack4(src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]);
            if (i < wa_q.size()) begin
                chk({tag, "_addr"}, wa_q[i], b + 32'(4 * i));
                chk({tag, "_wdata"}, wd_q[i], ew);
            end
            if (i < ec_q.size()) chk({tag, "_echo"}, ec_q[i], ew);
        end
        chk({tag, "_idle_done"}, 32'(done), 32'd1);
        chk({tag, "_idle_inready"}, 32'(in_ready), 32'd0);
        chk({tag, "_idle_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_inready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_out0"}, out0, 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; rdy = 1'b0; base = 32'sd0; count = 32'sd0;
        in_data = 8'd0; in_valid = 1'b0; mem_ack = 1'b0;
        ackd = 0; rdyd = 0; rrand = 1'b0; vrand = 1'b0; we_age = 0; v_age = 0;
        we_prev = 1'b0; ack_prev = 1'b0; val_prev = 1'b0; rdy_prev = 1'b0;
        rst_prev = 1'b1; addr_prev = 32'd0; data_prev = 32'd0; out0_prev = 32'd0;
        clear_rec();
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("por");

        // Basic write, with extra bytes offered that must not be consumed.
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_txn("basic", 32'd256, 32'd2, 0, 0, 1'b0, 1'b0, 4);

        // Memory stall of 5 cycles.
        src = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_txn("stall", 32'd264, 32'd1, 5, 0, 1'b0, 1'b0, 2);

        // Echo backpressure: _ready low for 3 cycles per word.
        src = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        run_txn("bp", 32'h0000_1000, 32'd2, 0, 3, 1'b0, 1'b0, 0);

        // Zero and negative counts.
        src.delete();
        run_txn("zero", 32'd512, 32'd0, 0, 0, 1'b0, 1'b0, 4);
        run_txn("neg", 32'd512, 32'hFFFF_FFFD, 0, 0, 1'b0, 1'b0, 4);

        // Address wraparound at the top of the 32-bit space.
        src.delete();
        for (int j = 0; j < 16; j++) src.push_back(8'($urandom));
        run_txn("wrap", 32'hFFFF_FFF8, 32'd4, 1, 1, 1'b0, 1'b0, 0);

        // Reset after two bytes of a word have been accepted.
        ackd = 0; rdyd = 0; rrand = 1'b0; vrand = 1'b0;
        bq = '{8'hA1, 8'hA2};
        clear_rec();
        base = 32'sd100; count = 32'sd1; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (consumed < 2 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("midrst_consumed", 32'(consumed), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("midrst");
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_txn("after_rst", 32'd0, 32'd1, 0, 0, 1'b0, 1'b0, 0);

        // Random transactions.
        for (int t = 0; t < 8; t++) begin
            cnt = $urandom_range(1, 4);
            src.delete();
            for (int j = 0; j < 4 * cnt; j++) src.push_back(8'($urandom));
            run_txn("rand", $urandom, 32'(cnt), $urandom_range(0, 3), $urandom_range(0, 2),
                    (t % 2) == 1, (t % 4) >= 2, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/write8to32.md
Name: write8to32

Overview:
- Byte-to-word packer and memory writer. Inverse direction of the 32-to-8 memory reader.
- After a start pulse, accepts a stream of 8-bit bytes and packs each group of 4 into a 32-bit word.
- Writes each word to memory at consecutive addresses from `base`.
- Echoes each written word on the standard `_valid`/`_out0` output stream.
- Sits between a byte producer (generator module or testbench) and the shared data memory.

Parameters:
- ADDR_STRIDE, 4, address increment per written word (byte addressing).

Ports:
- _clock  input  1  system clock; all logic on posedge.
- _reset  input  1  synchronous, active-high reset.
- _start  input  1  start pulse; sampled only while idle.
- _ready  input  1  downstream ready for the `_out0` echo stream.
- base  input  32 signed  first word address; latched on accepted `_start`.
- count  input  32 signed  number of words to write; latched on accepted `_start`.
- in_data  input  8  incoming byte.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block accepts a byte this cycle.
- mem_addr  output  32 signed  write address.
- mem_wdata  output  32  write data.
- mem_we  output  1  write request; held until `mem_ack`.
- mem_ack  input  1  memory accepted the write this cycle.
- _done  output  1  idle/finished indicator.
- _valid  output  1  `_out0` holds a written word.
- _out0  output  32 signed  copy of the last written word.

Behaviour:
- Reset values (on `_reset` high at posedge, from any state): state=IDLE, `_done`=1, `_valid`=0, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `_out0`=0, byte index=0, word index=0.
  - Reset mid-operation discards the partial word and any pending write.
- IDLE:
  - `_done`=1, `in_ready`=0.
  - `_start`=1 latches `base`/`count`; `_done` drops next cycle.
  - If count<=0, go to DONE with no writes and no input consumed.
  - Otherwise go to COLLECT.
- COLLECT:
  - `in_ready`=1.
  - Each cycle with in_valid&in_ready, store the byte in lane k (k=0..3; byte 0 -> bits[7:0], little-endian), then k++.
  - On the 4th byte, go to WRITE with `mem_wdata`=packed word and `mem_addr`=base + i*ADDR_STRIDE (i = word index, 32-bit wraparound), and assert `mem_we`.
  - No bubble is required on entry; a byte every cycle is accepted.
- WRITE:
  - `in_ready`=0; `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack`.
  - `mem_ack` in the same cycle `mem_we` first rises completes the write; minimum latency from 4th byte accept to `mem_we` is 1 cycle.
  - On `mem_ack`: `mem_we`=0; `_out0`=word; `_valid`=1; i++. Then go to ECHO.
- ECHO:
  - Hold `_valid`/`_out0` until `_ready`=1 at a posedge, then drop `_valid`.
  - If i==count go to DONE, else go to COLLECT with k=0.
  - With `_ready` tied high, `_valid` is a 1-cycle pulse.
- DONE:
  - `_done`=1, `_valid`=0; next cycle go to IDLE.
  - `_start` in the same cycle as DONE is ignored.
- `_start` outside IDLE is ignored.
- `base`/`count` are don't-care after the start cycle.
- `in_valid` while `in_ready`=0 is not consumed; the producer holds the byte.
- Address and index arithmetic is 32-bit, wrapping silently.

Optional Feature:
- Macro: WRITE8TO32_BIG_ENDIAN_EN.
- Defined: byte 0 -> bits[31:24], byte 3 -> bits[7:0].
- Undefined: little-endian as above.
- All timing is identical in both modes.

Test Plan:
- Basic write: base=256, count=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 on consecutive cycles, `mem_ack` tied 1, `_ready`=1 -> expected:
  - write 0x44332211 @256, then 0x88776655 @260;
  - `_valid` pulses twice with those values;
  - `_done`=1 after the second echo;
  - exactly 8 bytes consumed.
- Memory stall: base=264, count=1, `mem_ack` held low 5 cycles after `mem_we` rises -> expected:
  - `mem_we`/`mem_addr`=264/`mem_wdata` stable all 5 cycles;
  - `in_ready`=0 throughout;
  - a single write when `mem_ack`=1.
- Backpressure: count=2, `_ready`=0 for 3 cycles after the first word -> expected:
  - `_valid`=1 with `_out0` stable;
  - no second-word bytes accepted until `_ready` returns.
- Zero count: count=0 and count=-3 -> expected: `mem_we` never asserts, `in_ready` never asserts, `_done` returns high within 2 cycles.
- Reset mid-word: 2 bytes accepted, then `_reset` for 1 cycle -> expected:
  - all outputs at reset values;
  - a new start with base=0, count=1 and bytes 1,2,3,4 writes 0x04030201 @0.
- Big-endian build (`WRITE8TO32_BIG_ENDIAN_EN` defined): same stimulus as the basic write -> expected writes 0x11223344 @256 and 0x55667788 @260.
